shift_ser_ctl: RTL
==================

SHIFT_SER_CTL -- requirements
Module: shift_ser_ctl

Interface
REQ-001 Parameter WIDTH, default 24: shift-register width in bits, legal range 2..64.
REQ-002 Parameter CNT_W, default 5: length-field width; SHALL equal ceil(log2(WIDTH+1)).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port load_valid, input, 1: a new parallel word is offered.
REQ-006 Port load_ready, output, 1: the block accepts a word this cycle.
REQ-007 Port load_data, input, WIDTH: the parallel word to serialise.
REQ-008 Port load_len, input, CNT_W: number of bits to emit; 0 or any value above WIDTH means WIDTH.
REQ-009 Port msb_first, input, 1: shift direction, sampled only on load accept (1 = bit WIDTH-1 first).
REQ-010 Port abort, input, 1: terminates the current frame.
REQ-011 Port ser_valid, output, 1: ser_data holds a valid bit.
REQ-012 Port ser_ready, input, 1: the downstream consumer accepts the bit.
REQ-013 Port ser_data, output, 1: the current serial bit.
REQ-014 Port ser_last, output, 1: the current bit is the final bit of the frame.
REQ-015 Port busy, output, 1: the FSM is in SHIFT.
REQ-016 Port frame_cnt, output, 16: count of completed (non-aborted) frames, wrapping.

Function
REQ-017 The FSM SHALL have two states, IDLE and SHIFT; state, the shift register sh, the remaining-bit counter rem and the direction flag dir SHALL be registered.
REQ-018 A load accept SHALL be defined as load_valid & load_ready; a bit transfer as ser_valid & ser_ready.
REQ-019 load_ready SHALL be (state==IDLE) | (state==SHIFT & transfer & ser_last & ~abort), combinationally, so back-to-back frames need no bubble.
REQ-020 On load accept the block SHALL set sh=load_data, rem=effective length, dir=msb_first and state=SHIFT on the next edge.
REQ-021 In SHIFT: ser_valid=1; ser_data=sh[WIDTH-1] if dir else sh[0]; ser_last=(rem==1).
REQ-022 In IDLE: ser_valid=0, ser_last=0, ser_data=0.
REQ-023 On a transfer that is not the last bit, sh SHALL shift toward the emitted end with 0 filled at the opposite end, and rem SHALL decrement by 1.
REQ-024 On a transfer with ser_last=1, frame_cnt SHALL increment (wrapping 0xFFFF->0x0000), and state SHALL go to SHIFT (if a load is also accepted) or IDLE.
REQ-025 With ser_valid=1 and ser_ready=0, sh, rem, ser_data and ser_last SHALL hold unchanged (no drop, no duplicate).
REQ-026 abort in SHIFT SHALL force IDLE on the next edge; a transfer in the same cycle still counts as delivered; frame_cnt SHALL NOT increment; no load is accepted that cycle.
REQ-027 abort in IDLE SHALL have no effect.
REQ-028 Latency: the first bit SHALL appear on ser_data in the cycle after load accept; a frame of N bits with ser_ready held at 1 SHALL occupy exactly N cycles.

Reset
REQ-029 While rst=1 on a clock edge: state=IDLE, sh=0, rem=0, dir=0, frame_cnt=0; outputs therefore ser_valid=0, ser_last=0, ser_data=0, busy=0, load_ready=1 (after the edge).
REQ-030 rst SHALL override load, transfer and abort in the same cycle; a frame in progress SHALL be discarded without incrementing frame_cnt.

Verification
REQ-031 WIDTH=24, load 0xA5F00F, len=0, msb_first=1, ser_ready=1 -> 24 bits 1,0,1,0,0,1,0,1,1,1,1,1,0,... on consecutive cycles; ser_last on bit 24; frame_cnt=1.
REQ-032 Load 0x000003, len=4, msb_first=0 -> bits 1,1,0,0; ser_last on the 4th; block IDLE the next cycle.
REQ-033 Random ser_ready stalls (50%) across a 24-bit frame -> emitted sequence identical to the no-stall run; ser_data stable throughout each stall.
REQ-034 Second load_valid held high during the final bit -> load_ready=1 in that cycle; the next frame's first bit follows with no idle cycle; frame_cnt increments once per frame.
REQ-035 abort after bit 5 of a 24-bit frame -> ser_valid=0 next cycle, frame_cnt unchanged; rst asserted mid-frame -> all registers at reset values after one edge.
REQ-036 65536 one-bit frames -> frame_cnt wraps to 0x0000.

Source files
------------

// File: rtl/shift_ser_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_ser_ctl: parallel-load serialiser, ready/valid on both sides.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module shift_ser_ctl #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_len,
  input  logic             msb_first,
  input  logic             abort,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               dir_q, dir_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               in_shift;
  logic               xfer;
  logic               load_acc;
  logic [CNT_W-1:0]   eff_len;

  assign in_shift   = (state_q == SHIFT);
  assign ser_valid  = in_shift;
  assign ser_data   = in_shift & (dir_q ? sh_q[WIDTH-1] : sh_q[0]);
  assign ser_last   = in_shift & (rem_q == CNT_W'(1));
  assign busy       = in_shift;
  assign frame_cnt  = frame_cnt_q;

  assign xfer       = ser_valid & ser_ready;
  // Accepting during the final transfer lets the next frame start without a gap.
  assign load_ready = ~in_shift | (xfer & ser_last & ~abort);
  assign load_acc   = load_valid & load_ready;
  assign eff_len    = ((load_len == '0) || (load_len > WIDTH_C)) ? WIDTH_C : load_len;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    frame_cnt_d = frame_cnt_q;

    if (in_shift) begin
      if (abort) begin
        state_d = IDLE;
      end else if (xfer) begin
        if (ser_last) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end else begin
          sh_d  = dir_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
          rem_d = rem_q - CNT_W'(1);
        end
      end
    end

    // load_ready already excludes abort and mid-frame cycles.
    if (load_acc) begin
      state_d = SHIFT;
      sh_d    = load_data;
      rem_d   = eff_len;
      dir_d   = msb_first;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
`default_nettype wire
